axil_lockstep_cmp: RTL

AXIL_LOCKSTEP_CMP -- requirements
Module: axil_lockstep_cmp

---
 rtl/axil_lockstep_cmp.sv | 105 ++++++++++
 1 files changed

// File: rtl/axil_lockstep_cmp.sv
// axil_lockstep_cmp: compares NS shadow AXI-lite slaves against a gold slave and records mismatches
module axil_lockstep_cmp #(
  parameter int DW = 32,
  parameter int NS = 2,
  parameter int SETTLE = 2,
  parameter int TW = 16,
  parameter int CW = 8
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESET,
  input  logic             i_clear,
  input  logic [NS-1:0]    i_mask,
  input  logic             S_AXI_AWVALID,
  input  logic             S_AXI_WVALID,
  input  logic             S_AXI_ARVALID,
  input  logic             G_AWREADY,
  input  logic             G_WREADY,
  input  logic             G_ARREADY,
  input  logic             G_BVALID,
  input  logic             G_RVALID,
  input  logic [1:0]       G_BRESP,
  input  logic [1:0]       G_RRESP,
  input  logic [DW-1:0]    G_RDATA,
  input  logic [NS-1:0]    U_AWREADY,
  input  logic [NS-1:0]    U_WREADY,
  input  logic [NS-1:0]    U_ARREADY,
  input  logic [NS-1:0]    U_BVALID,
  input  logic [NS-1:0]    U_RVALID,
  input  logic [2*NS-1:0]  U_BRESP,
  input  logic [2*NS-1:0]  U_RRESP,
  input  logic [DW*NS-1:0] U_RDATA,
  output logic             o_armed,
  output logic [NS-1:0]    o_mismatch,
  output logic             o_error,
  output logic [2:0]       o_first_idx,
  output logic [2:0]       o_first_code,
  output logic [TW-1:0]    o_first_time,
  output logic [NS*CW-1:0] o_err_count
);
  localparam int AW = $clog2(SETTLE + 2);
  logic [AW-1:0] arm_cnt;
  logic [TW-1:0] ts;
  logic [NS-1:0] fail;
  logic [2:0] code [NS];
  logic [2:0] first_idx;
  logic [2:0] first_code;
  assign o_armed = !S_AXI_ARESET && arm_cnt == AW'(SETTLE);
  for (genvar k = 0; k < NS; k++) begin : g_sh
    logic [6:0] f;
    assign f = {G_RVALID && ({G_RRESP, G_RDATA} != {U_RRESP[2*k+:2], U_RDATA[DW*k+:DW]}),
                G_BVALID && (G_BRESP != U_BRESP[2*k+:2]),
                G_RVALID != U_RVALID[k],
                G_BVALID != U_BVALID[k],
                S_AXI_ARVALID && (G_ARREADY != U_ARREADY[k]),
                S_AXI_WVALID && (G_WREADY != U_WREADY[k]),
                S_AXI_AWVALID && (G_AWREADY != U_AWREADY[k])};
    assign fail[k] = o_armed && i_mask[k] && |f;
    assign code[k] = f[0] ? 3'd0 : f[1] ? 3'd1 : f[2] ? 3'd2 : f[3] ? 3'd3 :
                     f[4] ? 3'd4 : f[5] ? 3'd5 : 3'd6;
  end
  always_comb begin
    first_idx = '0;
    first_code = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (fail[k]) begin
        first_idx = 3'(k);
        first_code = code[k];
      end
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      arm_cnt <= '0;
      ts <= '0;
      o_mismatch <= '0;
      o_error <= 1'b0;
      o_first_idx <= '0;
      o_first_code <= '0;
      o_first_time <= '0;
      o_err_count <= '0;
    end else begin
      ts <= &ts ? ts : ts + 1'b1;
      if (arm_cnt != AW'(SETTLE)) arm_cnt <= arm_cnt + 1'b1;
      if (i_clear) begin
        o_mismatch <= '0;
        o_error <= 1'b0;
        o_first_idx <= '0;
        o_first_code <= '0;
        o_first_time <= '0;
        o_err_count <= '0;
      end else begin
        o_mismatch <= fail;
        if (!o_error && |fail) begin
          o_error <= 1'b1;
          o_first_idx <= first_idx;
          o_first_code <= first_code;
          o_first_time <= ts;
        end
        for (int k = 0; k < NS; k++)
          if (fail[k] && !(&o_err_count[k*CW+:CW]))
            o_err_count[k*CW+:CW] <= o_err_count[k*CW+:CW] + 1'b1;
      end
    end
  end
endmodule
